// File: rtl/gpr_wb_if.sv
// gpr_wb_if: handshake/bus bundle between the execute/memory datapath and the GPR write-back controller
//   master : upstream side (drives ALU/mem results, observes stall, ready and GPR write port)
//   slave  : controller side (consumes results, drives stall, ready, GPR write port, fifo_count)
//   DEPTH  : long-latency FIFO depth, sizes fifo_count
interface gpr_wb_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          alu_valid;
    logic [4:0]    alu_reg;
    logic [31:0]   alu_data;
    logic          alu_ovf;
    logic          alu_stall;
    logic          mem_valid;
    logic [4:0]    mem_reg;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic          rw;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic          overflow;
    logic [CW-1:0] fifo_count;
    modport master (
        output alu_valid, alu_reg, alu_data, alu_ovf, mem_valid, mem_reg, mem_data,
        input  alu_stall, mem_ready, rw, WriteReg, WriteData, overflow, fifo_count
    );
    modport slave (
        input  alu_valid, alu_reg, alu_data, alu_ovf, mem_valid, mem_reg, mem_data,
        output alu_stall, mem_ready, rw, WriteReg, WriteData, overflow, fifo_count
    );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: single GPR writer merging 1-cycle ALU results with FIFO-buffered long-latency results
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gpr_wb_if.slave (ALU result in, mem result handshake in, alu_stall out,
//           registered GPR write port rw/WriteReg/WriteData/overflow, fifo_count)
//   GPR_WB_BYPASS_EN : when defined, an accepted mem result skips the empty FIFO if nothing
//                      else wants the write port this cycle (latency 1 instead of 2)
module gpr_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic     clk,
    input logic     rst_n,
    gpr_wb_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_fifo_reg  [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_stall, r_rw, r_ovf;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdata;
    logic          w_ready, w_acc, w_alu_ok, w_nonempty, w_deq, w_byp, w_enq, w_win;

    assign w_ready    = r_count != CW'(DEPTH);
    assign w_acc      = bus.mem_valid && w_ready;
    assign w_alu_ok   = bus.alu_valid && bus.alu_reg != 5'd0 && !r_stall;
    assign w_nonempty = r_count != '0;
    // stall cycles and idle-ALU cycles both drain the head
    assign w_deq      = w_nonempty && !w_alu_ok;
`ifdef GPR_WB_BYPASS_EN
    assign w_byp      = !w_nonempty && !r_stall && !w_alu_ok && w_acc && bus.mem_reg != 5'd0;
`else
    assign w_byp      = 1'b0;
`endif
    assign w_enq      = w_acc && bus.mem_reg != 5'd0 && !w_byp;
    assign w_win      = w_alu_ok && w_nonempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_rw     <= 1'b0;
            r_wreg   <= 5'd0;
            r_wdata  <= 32'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_fifo_reg[r_wptr]  <= bus.mem_reg;
                r_fifo_data[r_wptr] <= bus.mem_data;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_deq)
                r_rptr <= r_rptr + 1'b1;
            r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
            // the STARVE_MAX-th consecutive win arms a one-cycle forced drain
            r_stall  <= w_win && r_starve == SW'(STARVE_MAX - 1);
            r_starve <= (w_win && r_starve != SW'(STARVE_MAX - 1)) ? r_starve + 1'b1 : '0;
            r_rw     <= w_alu_ok || w_deq || w_byp;
            if (w_alu_ok) begin
                r_wreg  <= bus.alu_reg;
                r_wdata <= bus.alu_data;
                r_ovf   <= bus.alu_ovf;
            end else if (w_deq) begin
                r_wreg  <= r_fifo_reg[r_rptr];
                r_wdata <= r_fifo_data[r_rptr];
                r_ovf   <= 1'b0;
            end else if (w_byp) begin
                r_wreg  <= bus.mem_reg;
                r_wdata <= bus.mem_data;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign bus.mem_ready  = w_ready;
    assign bus.alu_stall  = r_stall;
    assign bus.rw         = r_rw;
    assign bus.WriteReg   = r_wreg;
    assign bus.WriteData  = r_wdata;
    assign bus.overflow   = r_ovf;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb_gpr_wb_ctrl: directed self-checking bench for gpr_wb_ctrl (DEPTH=4, STARVE_MAX=8, default build)
module tb_gpr_wb_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   checks = 0;

    gpr_wb_if #(.DEPTH(4)) bus ();
    gpr_wb_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d, input logic o);
        bus.alu_valid = v;
        bus.alu_reg   = r;
        bus.alu_data  = d;
        bus.alu_ovf   = o;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mem_valid = v;
        bus.mem_reg   = r;
        bus.mem_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d, input logic o);
        chk({tag, "_rw"}, 64'(bus.rw), 64'd1);
        chk({tag, "_reg"}, 64'(bus.WriteReg), 64'(r));
        chk({tag, "_data"}, 64'(bus.WriteData), 64'(d));
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(o));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rw"}, 64'(bus.rw), 64'd0);
        chk({tag, "_reg"}, 64'(bus.WriteReg), 64'd0);
        chk({tag, "_data"}, 64'(bus.WriteData), 64'd0);
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
        chk({tag, "_stall"}, 64'(bus.alu_stall), 64'd0);
        chk({tag, "_cnt"}, 64'(bus.fifo_count), 64'd0);
        chk({tag, "_rdy"}, 64'(bus.mem_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_alu(0, 0, 0, 0);
        set_mem(0, 0, 0);
        repeat (2) tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("idle_rw", 64'(bus.rw), 64'd0);
        // ALU path
        set_alu(1, 5, 32'h1234, 1);
        tick();
        chk_wr("alu", 5, 32'h1234, 1);
        set_alu(1, 0, 32'h99, 0);
        tick();
        chk("alu0_rw", 64'(bus.rw), 64'd0);
        chk("alu0_hold_reg", 64'(bus.WriteReg), 64'd5);
        chk("alu0_hold_data", 64'(bus.WriteData), 64'h1234);
        chk("alu0_hold_ovf", 64'(bus.overflow), 64'd1);
        set_alu(0, 0, 0, 0);
        // mem ordering, latency 2
        set_mem(1, 3, 32'hA);
        tick();
        chk("mem1_rw", 64'(bus.rw), 64'd0);
        chk("mem1_cnt", 64'(bus.fifo_count), 64'd1);
        set_mem(1, 4, 32'hB);
        tick();
        chk_wr("mem3", 3, 32'hA, 0);
        chk("mem3_cnt", 64'(bus.fifo_count), 64'd1);
        set_mem(1, 5, 32'hC);
        tick();
        chk_wr("mem4", 4, 32'hB, 0);
        set_mem(0, 0, 0);
        tick();
        chk_wr("mem5", 5, 32'hC, 0);
        chk("mem5_cnt", 64'(bus.fifo_count), 64'd0);
        tick();
        chk("mem_idle_rw", 64'(bus.rw), 64'd0);
        // mem to reg 0: handshake completes, nothing stored or written
        set_mem(1, 0, 32'hFF);
        #1;
        chk("r0_rdy", 64'(bus.mem_ready), 64'd1);
        tick();
        chk("r0_cnt", 64'(bus.fifo_count), 64'd0);
        chk("r0_rw", 64'(bus.rw), 64'd0);
        // full FIFO under continuous ALU traffic, then starvation drain
        set_alu(1, 7, 32'h70, 1);
        for (int i = 0; i < 4; i++) begin
            set_mem(1, 5'(10 + i), 32'h100 + 32'(i));
            tick();
            chk("fill_cnt", 64'(bus.fifo_count), 64'(i + 1));
            chk("fill_reg", 64'(bus.WriteReg), 64'd7);
        end
        chk("full_rdy", 64'(bus.mem_ready), 64'd0);
        set_mem(1, 14, 32'h104);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_cnt", 64'(bus.fifo_count), 64'd4);
            chk("pre_stall", 64'(bus.alu_stall), 64'd0);
        end
        tick();
        chk("stall", 64'(bus.alu_stall), 64'd1);
        chk_wr("win8", 7, 32'h70, 1);
        chk("stall_rdy", 64'(bus.mem_ready), 64'd0);
        set_alu(0, 0, 0, 0);
        tick();
        chk_wr("drain10", 10, 32'h100, 0);
        chk("drain10_cnt", 64'(bus.fifo_count), 64'd3);
        chk("stall_off", 64'(bus.alu_stall), 64'd0);
        tick();
        chk_wr("drain11", 11, 32'h101, 0);
        chk("fifth_acc_cnt", 64'(bus.fifo_count), 64'd3);
        set_mem(0, 0, 0);
        tick();
        chk_wr("drain12", 12, 32'h102, 0);
        tick();
        chk_wr("drain13", 13, 32'h103, 0);
        tick();
        chk_wr("drain14", 14, 32'h104, 0);
        chk("drain_cnt", 64'(bus.fifo_count), 64'd0);
        // async reset with 3 entries queued
        set_alu(1, 8, 32'h80, 1);
        for (int i = 0; i < 3; i++) begin
            set_mem(1, 5'(20 + i), 32'h200 + 32'(i));
            tick();
        end
        chk("burst_cnt", 64'(bus.fifo_count), 64'd3);
        chk("burst_rw", 64'(bus.rw), 64'd1);
        set_alu(0, 0, 0, 0);
        set_mem(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("arst");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rw", 64'(bus.rw), 64'd0);
        chk("post_cnt", 64'(bus.fifo_count), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
